// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset CPU: sequences fetch, decode,
// execute, memory and writeback, drives datapath controls, counts retired instructions.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_we,
    output logic [1:0]       npc_sel,
    output logic             ir_we,
    output logic             rf_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic             dm_we,
    output logic             alu_src_b,
    output logic [2:0]       alu_op,
    output logic [2:0]       ext_op,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD,
        MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP
    } state_t;

    typedef struct packed {
        logic       pc_we;
        logic [1:0] npc_sel;
        logic       ir_we;
        logic       rf_we;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       dm_we;
        logic       alu_src_b;
        logic [2:0] alu_op;
        logic [2:0] ext_op;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;
    localparam logic [2:0] ALU_PASS = 3'd3;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    ctrl_t            ctl, ctl_o;

    logic is_r, is_addu, is_subu, is_jr, is_nop;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;

    assign is_r    = (opcode == OP_RTYPE);
    assign is_addu = is_r && (funct == 6'b100001);
    assign is_subu = is_r && (funct == 6'b100011);
    assign is_jr   = is_r && (funct == 6'b001000);
    assign is_nop  = is_r && (funct == 6'b000000);
    assign is_ori  = (opcode == OP_ORI);
    assign is_lui  = (opcode == OP_LUI);
    assign is_lw   = (opcode == OP_LW);
    assign is_sw   = (opcode == OP_SW);
    assign is_beq  = (opcode == OP_BEQ);
    assign is_j    = (opcode == OP_J);
    assign is_jal  = (opcode == OP_JAL);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (ctl_o.instr_done)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                if (is_addu || is_subu)              state_d = EXEC_R;
                else if (is_ori || is_lui)           state_d = EXEC_I;
                else if (is_lw || is_sw)             state_d = MEM_ADDR;
                else if (is_beq)                     state_d = BRANCH;
                else if (is_j || is_jal || is_jr)    state_d = JUMP;
                else                                 state_d = FETCH;
            end
            EXEC_R:   state_d = WB_R;
            EXEC_I:   state_d = WB_I;
            MEM_ADDR: state_d = is_lw ? MEM_RD : MEM_WR;
            MEM_RD:   state_d = WB_MEM;
            default:  state_d = FETCH;
        endcase
    end

    // NOTE: every field gets a default before the case so no output can
    // hold its value through an unlisted path and infer a latch.
    always_comb begin
        ctl = '0;
        if (state_q != FETCH) begin
            if (is_lw || is_sw || is_beq) ctl.ext_op = 3'd1;
            else if (is_lui)              ctl.ext_op = 3'd2;
        end
        case (state_q)
            FETCH: begin
                ctl.ir_we = 1'b1;
                ctl.pc_we = 1'b1;
            end
            DECODE: begin
                if (is_nop)
                    ctl.instr_done = 1'b1;
                else if (!(is_addu || is_subu || is_ori || is_lui || is_lw ||
                           is_sw || is_beq || is_j || is_jal || is_jr))
                    ctl.illegal = 1'b1;
            end
            EXEC_R, WB_R: begin
                ctl.alu_op = is_subu ? ALU_SUB : ALU_ADD;
                if (state_q == WB_R) begin
                    ctl.rf_we      = 1'b1;
                    ctl.reg_dst    = 2'd1;
                    ctl.instr_done = 1'b1;
                end
            end
            EXEC_I, WB_I: begin
                ctl.alu_src_b = 1'b1;
                ctl.alu_op    = is_lui ? ALU_PASS : ALU_OR;
                if (state_q == WB_I) begin
                    ctl.rf_we      = 1'b1;
                    ctl.instr_done = 1'b1;
                end
            end
            MEM_ADDR, MEM_RD, MEM_WR: begin
                ctl.alu_src_b = 1'b1;
                ctl.alu_op    = ALU_ADD;
                if (state_q == MEM_WR) begin
                    ctl.dm_we      = 1'b1;
                    ctl.instr_done = 1'b1;
                end
            end
            WB_MEM: begin
                ctl.rf_we      = 1'b1;
                ctl.wd_sel     = 2'd1;
                ctl.instr_done = 1'b1;
            end
            BRANCH: begin
                ctl.alu_op     = ALU_SUB;
                ctl.pc_we      = zero;
                ctl.npc_sel    = 2'd1;
                ctl.instr_done = 1'b1;
            end
            JUMP: begin
                ctl.pc_we      = 1'b1;
                ctl.instr_done = 1'b1;
                ctl.npc_sel    = is_jr ? 2'd3 : 2'd2;
                if (is_jal) begin
                    ctl.rf_we   = 1'b1;
                    ctl.reg_dst = 2'd2;
                    ctl.wd_sel  = 2'd2;
                end
            end
            default: ctl = '0;
        endcase
    end

    // While reset is held the state reads FETCH; mask it so no write fires.
    assign ctl_o = reset ? ctl : '0;

    assign pc_we      = ctl_o.pc_we;
    assign npc_sel    = ctl_o.npc_sel;
    assign ir_we      = ctl_o.ir_we;
    assign rf_we      = ctl_o.rf_we;
    assign reg_dst    = ctl_o.reg_dst;
    assign wd_sel     = ctl_o.wd_sel;
    assign dm_we      = ctl_o.dm_we;
    assign alu_src_b  = ctl_o.alu_src_b;
    assign alu_op     = ctl_o.alu_op;
    assign ext_op     = ctl_o.ext_op;
    assign instr_done = ctl_o.instr_done;
    assign illegal    = ctl_o.illegal;
    assign retired    = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle control vectors for each instruction
// class, reset abort, and counter wrap on a CNT_W=4 instance.
module tb_mc_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;

    logic        pc_we, ir_we, rf_we, dm_we, alu_src_b, instr_done, illegal;
    logic [1:0]  npc_sel, reg_dst, wd_sel;
    logic [2:0]  alu_op, ext_op;
    logic [31:0] retired;

    logic        s_pc_we, s_ir_we, s_rf_we, s_dm_we, s_alu_src_b, s_instr_done, s_illegal;
    logic [1:0]  s_npc_sel, s_reg_dst, s_wd_sel;
    logic [2:0]  s_alu_op, s_ext_op;
    logic [3:0]  s_retired;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_ret;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_we(pc_we), .npc_sel(npc_sel), .ir_we(ir_we), .rf_we(rf_we),
        .reg_dst(reg_dst), .wd_sel(wd_sel), .dm_we(dm_we), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .ext_op(ext_op), .instr_done(instr_done),
        .illegal(illegal), .retired(retired)
    );

    mc_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_we(s_pc_we), .npc_sel(s_npc_sel), .ir_we(s_ir_we), .rf_we(s_rf_we),
        .reg_dst(s_reg_dst), .wd_sel(s_wd_sel), .dm_we(s_dm_we), .alu_src_b(s_alu_src_b),
        .alu_op(s_alu_op), .ext_op(s_ext_op), .instr_done(s_instr_done),
        .illegal(s_illegal), .retired(s_retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [18:0] obs, obs4;
    assign obs  = {pc_we, npc_sel, ir_we, rf_we, reg_dst, wd_sel, dm_we,
                   alu_src_b, alu_op, ext_op, instr_done, illegal};
    assign obs4 = {s_pc_we, s_npc_sel, s_ir_we, s_rf_we, s_reg_dst, s_wd_sel, s_dm_we,
                   s_alu_src_b, s_alu_op, s_ext_op, s_instr_done, s_illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected control vector, fields in port order.
    function automatic logic [18:0] v(input logic pc, input logic [1:0] npc,
                                      input logic ir, input logic rf,
                                      input logic [1:0] rd, input logic [1:0] wd,
                                      input logic dm, input logic sb,
                                      input logic [2:0] op, input logic [2:0] ext,
                                      input logic dn, input logic il);
        return {pc, npc, ir, rf, rd, wd, dm, sb, op, ext, dn, il};
    endfunction

    localparam logic [18:0] V_FETCH = 19'h48000;  // pc_we=1, ir_we=1
    localparam logic [18:0] V_ZERO  = 19'h0;

    // Checks one cycle at the falling edge, then advances past the next rising edge.
    task automatic cyc(input string tag, input logic [18:0] e);
        @(negedge clk);
        check({tag, ".ctl"},  {13'd0, obs},  {13'd0, e});
        check({tag, ".ctl4"}, {13'd0, obs4}, {13'd0, e});
        check({tag, ".ret"},  retired, exp_ret);
        check({tag, ".ret4"}, {28'd0, s_retired}, {28'd0, exp_ret[3:0]});
        if (e[1]) exp_ret = exp_ret + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        opcode = op;
        funct  = fn;
        zero   = z;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_ret  = 0;
        reset    = 1'b0;
        instr(6'b001101, 6'd0, 1'b0);
        #1;
        for (int i = 0; i < 3; i++) cyc("reset_hold", V_ZERO);
        reset = 1'b1;

        // ori: 4 cycles, ext_op 0 throughout
        cyc("ori.fetch",  V_FETCH);
        cyc("ori.decode", V_ZERO);
        cyc("ori.exec",   v(0,0,0,0,0,0,0,1,3'd2,3'd0,0,0));
        cyc("ori.wb",     v(0,0,0,1,0,0,0,1,3'd2,3'd0,1,0));

        // lui
        instr(6'b001111, 6'd0, 1'b0);
        cyc("lui.fetch",  V_FETCH);
        cyc("lui.decode", v(0,0,0,0,0,0,0,0,3'd0,3'd2,0,0));
        cyc("lui.exec",   v(0,0,0,0,0,0,0,1,3'd3,3'd2,0,0));
        cyc("lui.wb",     v(0,0,0,1,0,0,0,1,3'd3,3'd2,1,0));

        // lw: 5 cycles
        instr(6'b100011, 6'd0, 1'b0);
        cyc("lw.fetch",  V_FETCH);
        cyc("lw.decode", v(0,0,0,0,0,0,0,0,3'd0,3'd1,0,0));
        cyc("lw.addr",   v(0,0,0,0,0,0,0,1,3'd0,3'd1,0,0));
        cyc("lw.rd",     v(0,0,0,0,0,0,0,1,3'd0,3'd1,0,0));
        cyc("lw.wb",     v(0,0,0,1,0,2'd1,0,0,3'd0,3'd1,1,0));

        // beq taken / not taken
        instr(6'b000100, 6'd0, 1'b1);
        cyc("beq1.fetch",  V_FETCH);
        cyc("beq1.decode", v(0,0,0,0,0,0,0,0,3'd0,3'd1,0,0));
        cyc("beq1.branch", v(1,2'd1,0,0,0,0,0,0,3'd1,3'd1,1,0));
        instr(6'b000100, 6'd0, 1'b0);
        cyc("beq0.fetch",  V_FETCH);
        cyc("beq0.decode", v(0,0,0,0,0,0,0,0,3'd0,3'd1,0,0));
        cyc("beq0.branch", v(0,2'd1,0,0,0,0,0,0,3'd1,3'd1,1,0));

        // jal, jr, j
        instr(6'b000011, 6'd0, 1'b0);
        cyc("jal.fetch",  V_FETCH);
        cyc("jal.decode", V_ZERO);
        cyc("jal.jump",   v(1,2'd2,0,1,2'd2,2'd2,0,0,3'd0,3'd0,1,0));
        instr(6'b000000, 6'b001000, 1'b0);
        cyc("jr.fetch",  V_FETCH);
        cyc("jr.decode", V_ZERO);
        cyc("jr.jump",   v(1,2'd3,0,0,0,0,0,0,3'd0,3'd0,1,0));
        instr(6'b000010, 6'd0, 1'b0);
        cyc("j.fetch",  V_FETCH);
        cyc("j.decode", V_ZERO);
        cyc("j.jump",   v(1,2'd2,0,0,0,0,0,0,3'd0,3'd0,1,0));

        // addu / subu
        instr(6'b000000, 6'b100001, 1'b0);
        cyc("addu.fetch",  V_FETCH);
        cyc("addu.decode", V_ZERO);
        cyc("addu.exec",   V_ZERO);
        cyc("addu.wb",     v(0,0,0,1,2'd1,0,0,0,3'd0,3'd0,1,0));
        instr(6'b000000, 6'b100011, 1'b0);
        cyc("subu.fetch",  V_FETCH);
        cyc("subu.decode", V_ZERO);
        cyc("subu.exec",   v(0,0,0,0,0,0,0,0,3'd1,3'd0,0,0));
        cyc("subu.wb",     v(0,0,0,1,2'd1,0,0,0,3'd1,3'd0,1,0));

        // sw: 4 cycles
        instr(6'b101011, 6'd0, 1'b0);
        cyc("sw.fetch",  V_FETCH);
        cyc("sw.decode", v(0,0,0,0,0,0,0,0,3'd0,3'd1,0,0));
        cyc("sw.addr",   v(0,0,0,0,0,0,0,1,3'd0,3'd1,0,0));
        cyc("sw.wr",     v(0,0,0,0,0,0,1,1,3'd0,3'd1,1,0));

        // illegal opcode, illegal R-type funct, nop
        instr(6'b111111, 6'd0, 1'b0);
        cyc("ill.fetch",  V_FETCH);
        cyc("ill.decode", v(0,0,0,0,0,0,0,0,3'd0,3'd0,0,1));
        instr(6'b000000, 6'b100000, 1'b0);
        cyc("illr.fetch",  V_FETCH);
        cyc("illr.decode", v(0,0,0,0,0,0,0,0,3'd0,3'd0,0,1));
        instr(6'b000000, 6'b000000, 1'b0);
        cyc("nop.fetch",  V_FETCH);
        cyc("nop.decode", v(0,0,0,0,0,0,0,0,3'd0,3'd0,1,0));

        // reset asserted mid MEM_WR aborts the store
        instr(6'b101011, 6'd0, 1'b0);
        cyc("swa.fetch",  V_FETCH);
        cyc("swa.decode", v(0,0,0,0,0,0,0,0,3'd0,3'd1,0,0));
        cyc("swa.addr",   v(0,0,0,0,0,0,0,1,3'd0,3'd1,0,0));
        #2;
        check("swa.dm_we_before", {31'd0, dm_we}, 32'd1);
        reset = 1'b0;
        #1;
        check("swa.ctl_in_reset", {13'd0, obs}, 32'd0);
        check("swa.ret_in_reset", retired, 32'd0);
        check("swa.ret4_in_reset", {28'd0, s_retired}, 32'd0);
        exp_ret = 0;
        @(posedge clk);
        #1;
        check("swa.ctl_held", {13'd0, obs}, 32'd0);
        reset = 1'b1;
        cyc("swa.refetch", V_FETCH);
        cyc("swa.redecode", v(0,0,0,0,0,0,0,0,3'd0,3'd1,0,0));
        cyc("swa.readdr",   v(0,0,0,0,0,0,0,1,3'd0,3'd1,0,0));
        cyc("swa.rewr",     v(0,0,0,0,0,0,1,1,3'd0,3'd1,1,0));

        // 16 nops: the 4-bit counter returns to where it started (1 -> 17 mod 16 = 1)
        instr(6'b000000, 6'b000000, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cyc("wrap.fetch",  V_FETCH);
            cyc("wrap.decode", v(0,0,0,0,0,0,0,0,3'd0,3'd0,1,0));
        end
        @(negedge clk);
        check("wrap.ret",  retired, 32'd17);
        check("wrap.ret4", {28'd0, s_retired}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
